// File: rtl/mem_burst_master_pkg.sv
// Shared encodings and helpers for the main-memory burst master.
package mem_burst_master_pkg;

   typedef enum logic [1:0] {
      ACC_1  = 2'b00,
      ACC_4  = 2'b01,
      ACC_8  = 2'b10,
      ACC_16 = 2'b11
   } acc_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      ERR  = 2'b11
   } state_e;

   // A request is only admitted when a full 16-word burst is guaranteed to fit.
   localparam int MIN_HEADROOM = 16;

   function automatic logic [4:0] burst_len(input logic [1:0] code);
      case (acc_size_e'(code))
         ACC_1:   return 5'd1;
         ACC_4:   return 5'd4;
         ACC_8:   return 5'd8;
         default: return 5'd16;
      endcase
   endfunction

endpackage

// File: rtl/mem_burst_master_rd_fifo.sv
// Synchronous FIFO buffering returned read words; power-of-two depth.
module mem_rd_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] storage [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = storage[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) storage[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_burst_master.sv
// Main-memory initiator: single-word writes and buffered burst reads.
module mem_burst_master
   import mem_burst_master_pkg::*;
#(
   parameter int ADDRESS_SIZE = 32,
   parameter int DATA_SIZE    = 32,
   parameter int ACCESS_SIZE  = 2,
   parameter int FIFO_DEPTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_wren,
   input  logic [ADDRESS_SIZE-1:0]  req_addr,
   input  logic [ACCESS_SIZE-1:0]   req_acc_size,
   input  logic [DATA_SIZE-1:0]     req_wdata,
   output logic [DATA_SIZE-1:0]     rd_data,
   output logic                     rd_last,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic                     err,
   output logic [ADDRESS_SIZE-1:0]  mem_addr,
   output logic [DATA_SIZE-1:0]     mem_d_in,
   output logic [ACCESS_SIZE-1:0]   mem_acc_size,
   output logic                     mem_wren,
   output logic                     mem_en,
   input  logic [DATA_SIZE-1:0]     mem_d_out
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e                  state;
   state_e                  next_state;
   logic [ACCESS_SIZE-1:0]  acc_q;
   logic [4:0]              beat;
   logic                    last_beat;
   logic                    handshake;
   logic                    push;
   logic                    pop;
   logic [DATA_SIZE:0]      head;
   logic [CW-1:0]           fifo_count;
   logic                    fifo_empty;
   logic                    fifo_full;

   assign req_ready = (state == IDLE) && (int'(fifo_count) <= FIFO_DEPTH - MIN_HEADROOM);
   assign handshake = req_valid && req_ready;
   assign last_beat = (beat == burst_len(acc_q) - 5'd1);
   assign push      = (state == RD) && !fifo_full;
   assign rd_valid  = !fifo_empty;
   assign pop       = rd_valid && rd_ready;
   assign rd_data   = head[DATA_SIZE:1];
   assign rd_last   = !fifo_empty && head[0];

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (handshake) begin
               if (req_addr[1:0] != 2'b00) next_state = ERR;
               else if (req_wren)          next_state = WR;
               else                        next_state = RD;
            end
         end
         RD:      if (last_beat) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Memory pins are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         acc_q        <= '0;
         beat         <= '0;
         err          <= 1'b0;
         mem_en       <= 1'b0;
         mem_wren     <= 1'b0;
         mem_acc_size <= '0;
         mem_addr     <= '0;
         mem_d_in     <= '0;
      end else begin
         state <= next_state;
         beat  <= (state == RD && !last_beat) ? beat + 5'd1 : 5'd0;
         err   <= (next_state == ERR);
         if (handshake) acc_q <= req_acc_size;
         mem_en   <= (next_state == RD) || (next_state == WR);
         mem_wren <= (next_state == WR);
         if (next_state == RD) mem_acc_size <= handshake ? req_acc_size : acc_q;
         else                  mem_acc_size <= '0;
         if (handshake && next_state != ERR) mem_addr <= req_addr;
         if (handshake && next_state == WR)  mem_d_in <= req_wdata;
      end
   end

   mem_rd_fifo #(
      .WIDTH (DATA_SIZE + 1),
      .DEPTH (FIFO_DEPTH)
   ) rd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({mem_d_out, last_beat}),
      .pop       (pop),
      .pop_data  (head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule
